jhash_word_engine: RTL

//  Parametrised lookup3 hashword() engine: length-prefixed stream of 32-bit words, 3 words per beat.

---
 rtl/jhash_word_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/jhash_word_engine.sv
// jhash_word_engine: lookup3 hashword() engine.
// Accepts a length-prefixed stream of 32-bit words, three words per beat, and
// runs the lookup3 mix()/final() schedules one rotate step per clock.
// Optional feature macro: JHASH_DUAL_OUT_EN adds hash_out2 (final b, the
// secondary value of hashword2).
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
// in_ready is high only in LOAD and does not depend on in_valid; in_valid may
// be asserted at any time and is ignored outside LOAD.
module jhash_word_engine #(
  parameter int unsigned LEN_W      = 16,
  parameter logic [31:0] INIT_CONST = 32'hdeadbeef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      seed,
  output logic             busy,
  input  logic [95:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      hash_out,
  output logic             hash_valid
`ifdef JHASH_DUAL_OUT_EN
  , output logic [31:0]    hash_out2
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MIX   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [31:0]      a, b, c;
  logic [31:0]      a_n, b_n, c_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [2:0]       step, step_n;
  logic [31:0]      w0, w1, w2;
  logic [31:0]      init_v;

  function automatic logic [31:0] rot(input logic [31:0] x, input int unsigned k);
    return (x << k) | (x >> (32 - k));
  endfunction

  assign w0 = in_data[31:0];
  assign w1 = in_data[63:32];
  assign w2 = in_data[95:64];

  // Length is counted in bytes (words << 2) in the initial value, as lookup3 does.
  assign init_v = INIT_CONST + (32'(len) << 2) + seed;

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      rem      <= '0;
      step     <= '0;
      hash_out <= '0;
`ifdef JHASH_DUAL_OUT_EN
      hash_out2 <= '0;
`endif
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      c     <= c_n;
      rem   <= rem_n;
      step  <= step_n;
      if (state_n == S_DONE && state != S_DONE) begin
        hash_out <= c_n;
`ifdef JHASH_DUAL_OUT_EN
        hash_out2 <= b_n;
`endif
      end
    end
  end

  // Next state, one mix/final step per cycle, and handshake outputs.
  always_comb begin
    state_n    = state;
    a_n        = a;
    b_n        = b;
    c_n        = c;
    rem_n      = rem;
    step_n     = step;
    busy       = (state != S_IDLE);
    in_ready   = 1'b0;
    hash_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          a_n     = init_v;
          b_n     = init_v;
          c_n     = init_v;
          rem_n   = len;
          step_n  = 3'd0;
          state_n = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          step_n = 3'd0;
          if (rem > LEN_W'(3)) begin
            a_n     = a + w0;
            b_n     = b + w1;
            c_n     = c + w2;
            rem_n   = rem - LEN_W'(3);
            state_n = S_MIX;
          end else begin
            // Tail of 1..3 words; an exact 3-word tail still goes to FINAL.
            a_n = a + w0;
            if (rem >= LEN_W'(2)) b_n = b + w1;
            if (rem == LEN_W'(3)) c_n = c + w2;
            state_n = S_FINAL;
          end
        end
      end
      S_MIX: begin
        step_n = step + 3'd1;
        case (step)
          3'd0: begin a_n = (a - c) ^ rot(c, 4);  c_n = c + b; end
          3'd1: begin b_n = (b - a) ^ rot(a, 6);  a_n = a + c; end
          3'd2: begin c_n = (c - b) ^ rot(b, 8);  b_n = b + a; end
          3'd3: begin a_n = (a - c) ^ rot(c, 16); c_n = c + b; end
          3'd4: begin b_n = (b - a) ^ rot(a, 19); a_n = a + c; end
          default: begin
            c_n     = (c - b) ^ rot(b, 4);
            b_n     = b + a;
            step_n  = 3'd0;
            state_n = S_LOAD;
          end
        endcase
      end
      S_FINAL: begin
        step_n = step + 3'd1;
        case (step)
          3'd0: c_n = (c ^ b) - rot(b, 14);
          3'd1: a_n = (a ^ c) - rot(c, 11);
          3'd2: b_n = (b ^ a) - rot(a, 25);
          3'd3: c_n = (c ^ b) - rot(b, 16);
          3'd4: a_n = (a ^ c) - rot(c, 4);
          3'd5: b_n = (b ^ a) - rot(a, 14);
          default: begin
            c_n     = (c ^ b) - rot(b, 24);
            step_n  = 3'd0;
            state_n = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        hash_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
